spi_slave: RTL



---
 rtl/spi_slave_if.sv | 35 +++
 rtl/spi_slave.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the core-side receive/transmit handshake of spi_slave.
//
// Receive handshake: rx_valid marks rx_data as a fresh byte. In the default
// build it is a one-cycle strobe and rx_ack is ignored. With
// SPI_SLAVE_RX_HANDSHAKE_EN defined, rx_valid holds until the consumer samples
// rx_ack high; a byte completing while rx_valid is still high overwrites
// rx_data and sets the sticky rx_overrun.
// Transmit handshake: tx_load is a one-cycle write strobe for tx_data. It is
// always accepted, and the last write wins. tx_full shows a byte waiting for
// the shifter.
interface spi_slave_if;
  logic       sck;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_full;

  modport slave (
    input  sck, ss_n, mosi, rx_ack, tx_data, tx_load,
    output miso, miso_oe, busy, rx_data, rx_valid, rx_overrun, tx_full
  );

  modport master (
    output sck, ss_n, mosi, rx_ack, tx_data, tx_load,
    input  miso, miso_oe, busy, rx_data, rx_valid, rx_overrun, tx_full
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames, oversampled in the clk domain.
// Optional feature macro: SPI_SLAVE_RX_HANDSHAKE_EN turns rx_valid into a
// level cleared by rx_ack and enables the sticky rx_overrun flag.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic sck_s, ss_s, mosi_s;
  logic sck_d, ss_d;

  logic [2:0] bit_cnt;
  logic [7:0] rx_shift;
  // Bits of the current reply byte not yet presented on miso.
  logic [6:0] tx_shift;
  logic [7:0] tx_buf;
  logic       tx_full;
  logic       byte_done;

  logic       miso, miso_oe, busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic rise, fall, ss_fall, reload;
  logic [7:0] next_tx;

  assign rise    = sck_s & ~sck_d & ~ss_s;
  assign fall    = ~sck_s & sck_d & ~ss_s;
  assign ss_fall = ss_d & ~ss_s;
  assign reload  = ss_fall | (fall & (bit_cnt == 3'd0));
  // A load in the reload cycle bypasses the buffer straight into the shifter.
  assign next_tx = bus.tx_load ? bus.tx_data : (tx_full ? tx_buf : IDLE_BYTE);

  // Synchronizers and edge-detect delay registers; ss_n idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sck_d     <= sck_s;
      ss_d      <= ss_s;
    end
  end

  // Bit counter, receive shifter and miso driver for the selected frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 7'h00;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      miso_oe   <= ~ss_s;
      busy      <= ~ss_s;
      byte_done <= 1'b0;
      if (ss_s) begin
        // Deselected: partial byte is dropped and sck is ignored.
        bit_cnt <= 3'd0;
        miso    <= 1'b0;
      end else if (ss_fall) begin
        bit_cnt  <= 3'd0;
        miso     <= next_tx[7];
        tx_shift <= next_tx[6:0];
      end else begin
        if (rise) begin
          rx_shift <= {rx_shift[6:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            byte_done <= 1'b1;
        end
        if (fall) begin
          if (bit_cnt == 3'd0) begin
            miso     <= next_tx[7];
            tx_shift <= next_tx[6:0];
          end else begin
            miso     <= tx_shift[6];
            tx_shift <= {tx_shift[5:0], 1'b0};
          end
        end
      end
    end
  end

  // One-deep transmit buffer; a shifter reload empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
    end else if (reload) begin
      tx_full <= 1'b0;
    end else if (bus.tx_load) begin
      tx_buf  <= bus.tx_data;
      tx_full <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_RX_HANDSHAKE_EN
  // Level-style rx_valid; completion beats a same-cycle acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (byte_done) begin
      rx_data  <= rx_shift;
      rx_valid <= 1'b1;
      if (rx_valid)
        rx_overrun <= 1'b1;
    end else if (bus.rx_ack) begin
      rx_valid <= 1'b0;
    end
  end
`else
  logic unused_rx_ack;
  assign unused_rx_ack = bus.rx_ack;
  assign rx_overrun    = 1'b0;

  // One-cycle rx_valid strobe per completed byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= byte_done;
      if (byte_done)
        rx_data <= rx_shift;
    end
  end
`endif

  assign bus.miso       = miso;
  assign bus.miso_oe    = miso_oe;
  assign bus.busy       = busy;
  assign bus.rx_data    = rx_data;
  assign bus.rx_valid   = rx_valid;
  assign bus.rx_overrun = rx_overrun;
  assign bus.tx_full    = tx_full;

endmodule
